// File: rtl/lf_ctrl_pkg.sv
// Shared constants for the LF mode sequencer: command opcodes, major-mode
// codes, sequencer states and the power-on defaults.
package lf_ctrl_pkg;

  localparam logic [3:0] FPGA_CMD_SET_CONFREG               = 4'd1;
  localparam logic [3:0] FPGA_CMD_SET_DIVISOR               = 4'd2;
  localparam logic [3:0] FPGA_CMD_SET_EDGE_DETECT_THRESHOLD = 4'd3;

  localparam logic [2:0] LF_READER      = 3'd0;
  localparam logic [2:0] LF_EDGE_DETECT = 3'd1;
  localparam logic [2:0] LF_PASSTHRU    = 3'd2;
  localparam logic [2:0] LF_ADC         = 3'd3;
  localparam logic [2:0] LF_OFF         = 3'd7;

  localparam int          GUARD_CYCLES_DEF  = 64;
  localparam int          SETTLE_CYCLES_DEF = 16;
  localparam int          DRAIN_TIMEOUT_DEF = 256;
  localparam logic [7:0]  DIV_DEFAULT_VAL   = 8'd95;
  localparam logic [7:0]  THR_DEFAULT_VAL   = 8'd127;
  localparam logic [11:0] CONF_RESET        = 12'h1C0;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    BLANK,
    COMMIT,
    SETTLE
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lf_cmd_slot.sv
// One-deep holding register for commands that arrive while the sequencer is
// busy, with a sticky overflow flag for commands that find it occupied.
module lf_cmd_slot (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clr_i,
  input  logic [15:0] word_i,
  output logic        full_o,
  output logic [15:0] word_o,
  output logic        overflow_o
);

  logic        full_q, full_d;
  logic        ovf_q, ovf_d;
  logic [15:0] word_q, word_d;
  logic        drop;

  // A push only loses data when the slot is occupied and not being drained.
  assign drop = push_i & full_q & ~pop_i;

  always_comb begin
    full_d = full_q & ~pop_i;
    word_d = word_q;
    if (push_i && !drop) begin
      full_d = 1'b1;
      word_d = word_i;
    end
    ovf_d = drop | (ovf_q & ~clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      word_q <= '0;
    end else begin
      full_q <= full_d;
      ovf_q  <= ovf_d;
      word_q <= word_d;
    end
  end

  assign full_o     = full_q;
  assign word_o     = word_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/lf_mode_sequencer.sv
// Command decoder for the LF image: applies cheap updates immediately and
// walks major-mode / divisor changes through drain, blank, commit and settle.
module lf_mode_sequencer
  import lf_ctrl_pkg::*;
#(
  parameter int         GUARD_CYCLES  = GUARD_CYCLES_DEF,
  parameter int         SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int         DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
  parameter logic [7:0] DIV_DEFAULT   = DIV_DEFAULT_VAL,
  parameter logic [7:0] THR_DEFAULT   = THR_DEFAULT_VAL
) (
  input  logic        pck0,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_word,
  input  logic        ssp_frame_in,
  input  logic        ovf_clr,
  output logic [11:0] conf_word,
  output logic [2:0]  major_mode,
  output logic        lf_field,
  output logic        lf_ed_toggle_mode,
  output logic [7:0]  divisor,
  output logic [7:0]  lf_ed_threshold,
  output logic        mute,
  output logic        busy,
  output logic        cmd_overflow
);

  localparam int CNT_W = $clog2(max3(GUARD_CYCLES, SETTLE_CYCLES, DRAIN_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      conf_q, conf_d;
  logic [7:0]       div_q, div_d;
  logic [7:0]       thr_q, thr_d;
  logic [11:0]      tgt_q, tgt_d;
  logic             tgt_conf_q, tgt_conf_d;

  logic        idle;
  logic        slot_full, slot_push, slot_pop;
  logic [15:0] slot_word, cmd_cur;
  logic        cmd_go;
  logic [3:0]  cmd_op;
  logic [11:0] cmd_data;

  // The held command always wins over a live strobe, which then refills the slot.
  assign idle      = (state_q == IDLE);
  assign slot_pop  = idle & slot_full;
  assign slot_push = cmd_valid & (~idle | slot_full);
  assign cmd_go    = idle & (slot_full | cmd_valid);
  assign cmd_cur   = slot_full ? slot_word : cmd_word;
  assign cmd_op    = cmd_cur[15:12];
  assign cmd_data  = cmd_cur[11:0];

  lf_cmd_slot u_slot (
    .clk_i      (pck0),
    .rst_i      (rst),
    .push_i     (slot_push),
    .pop_i      (slot_pop),
    .clr_i      (ovf_clr),
    .word_i     (cmd_word),
    .full_o     (slot_full),
    .word_o     (slot_word),
    .overflow_o (cmd_overflow)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
    conf_d     = conf_q;
    div_d      = div_q;
    thr_d      = thr_q;
    tgt_d      = tgt_q;
    tgt_conf_d = tgt_conf_q;
    case (state_q)
      IDLE: begin
        if (cmd_go) begin
          case (cmd_op)
            FPGA_CMD_SET_EDGE_DETECT_THRESHOLD: thr_d = cmd_data[7:0];
            FPGA_CMD_SET_CONFREG: begin
              if (cmd_data[8:6] == conf_q[8:6]) begin
                conf_d = cmd_data;
              end else begin
                tgt_d      = cmd_data;
                tgt_conf_d = 1'b1;
                state_d    = DRAIN;
                cnt_d      = DRAIN_LOAD;
              end
            end
            FPGA_CMD_SET_DIVISOR: begin
              if (cmd_data[7:0] != div_q) begin
                tgt_d      = {4'h0, cmd_data[7:0]};
                tgt_conf_d = 1'b0;
                state_d    = DRAIN;
                cnt_d      = DRAIN_LOAD;
              end
            end
            default: ;
          endcase
        end
      end
      DRAIN: begin
        if (!ssp_frame_in || cnt_q == '0) begin
          state_d = BLANK;
          cnt_d   = GUARD_LOAD;
        end
      end
      BLANK: begin
        if (cnt_q == '0) begin
          state_d = COMMIT;
          cnt_d   = '0;
        end
      end
      COMMIT: begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LOAD;
        if (tgt_conf_q) begin
          conf_d = tgt_q;
          if (tgt_q[8:6] == LF_EDGE_DETECT) thr_d = THR_DEFAULT;
        end else begin
          div_d = tgt_q[7:0];
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pck0) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      conf_q     <= CONF_RESET;
      div_q      <= DIV_DEFAULT;
      thr_q      <= THR_DEFAULT;
      tgt_q      <= '0;
      tgt_conf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      conf_q     <= conf_d;
      div_q      <= div_d;
      thr_q      <= thr_d;
      tgt_q      <= tgt_d;
      tgt_conf_q <= tgt_conf_d;
    end
  end

  assign mute              = (state_q == BLANK) || (state_q == COMMIT) || (state_q == SETTLE);
  assign busy              = ~idle;
  assign conf_word         = conf_q;
  assign major_mode        = conf_q[8:6];
  assign lf_field          = conf_q[0] & ~mute;
  assign lf_ed_toggle_mode = conf_q[1];
  assign divisor           = div_q;
  assign lf_ed_threshold   = thr_q;

endmodule

// File: tb/tb_lf_mode_sequencer.sv
// Directed bench for lf_mode_sequencer: fast-path updates, full mute
// sequences with drain timeout, pending-slot overflow and mid-sequence reset.
module tb_lf_mode_sequencer;

  logic        pck0 = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_word = '0;
  logic        ssp_frame_in = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [11:0] conf_word;
  logic [2:0]  major_mode;
  logic        lf_field;
  logic        lf_ed_toggle_mode;
  logic [7:0]  divisor;
  logic [7:0]  lf_ed_threshold;
  logic        mute;
  logic        busy;
  logic        cmd_overflow;

  int testsRun = 0;
  int testsFailed = 0;
  int firstMute, muteLen, fieldMuted;

  lf_mode_sequencer dut (
    .pck0              (pck0),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_word          (cmd_word),
    .ssp_frame_in      (ssp_frame_in),
    .ovf_clr           (ovf_clr),
    .conf_word         (conf_word),
    .major_mode        (major_mode),
    .lf_field          (lf_field),
    .lf_ed_toggle_mode (lf_ed_toggle_mode),
    .divisor           (divisor),
    .lf_ed_threshold   (lf_ed_threshold),
    .mute              (mute),
    .busy              (busy),
    .cmd_overflow      (cmd_overflow)
  );

  always #5 pck0 = ~pck0;

  task automatic tick();
    @(posedge pck0);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle strobe; returns in the first cycle after the strobe was sampled.
  task automatic applyStimulus(input logic [15:0] word);
    cmd_word  = word;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the strobe; stops when busy drops.
  task automatic measureMute(input int dropAt, input int budget,
                             output int first, output int len, output int fieldOn);
    int c;
    c = 1; first = -1; len = 0; fieldOn = 0;
    while (busy && c < budget) begin
      if (mute) begin
        if (first < 0) first = c;
        len++;
        if (lf_field) fieldOn++;
      end
      if (c == dropAt) ssp_frame_in = 1'b0;
      tick();
      c++;
    end
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_major_mode", 32'(major_mode), 32'd7);
    checkOutput("reset_conf_word", 32'(conf_word), 32'h1C0);
    checkOutput("reset_divisor", 32'(divisor), 32'd95);
    checkOutput("reset_threshold", 32'(lf_ed_threshold), 32'd127);
    checkOutput("reset_mute", 32'(mute), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_overflow", 32'(cmd_overflow), 32'd0);
    checkOutput("reset_field", 32'(lf_field), 32'd0);

    // Mode change OFF -> READER with field on, no frame in flight
    applyStimulus(16'h1001);
    checkOutput("rd_busy_start", 32'(busy), 32'd1);
    checkOutput("rd_mute_drain", 32'(mute), 32'd0);
    measureMute(-1, 400, firstMute, muteLen, fieldMuted);
    checkOutput("rd_first_mute", 32'(firstMute), 32'd2);
    checkOutput("rd_mute_len", 32'(muteLen), 32'd81);
    checkOutput("rd_field_muted", 32'(fieldMuted), 32'd0);
    checkOutput("rd_busy_end", 32'(busy), 32'd0);
    checkOutput("rd_major_mode", 32'(major_mode), 32'd0);
    checkOutput("rd_field", 32'(lf_field), 32'd1);
    checkOutput("rd_conf_word", 32'(conf_word), 32'h001);

    // Fast threshold write, then move into edge-detect mode
    applyStimulus(16'h3050);
    checkOutput("thr_fast_value", 32'(lf_ed_threshold), 32'h50);
    checkOutput("thr_fast_mute", 32'(mute), 32'd0);
    checkOutput("thr_fast_busy", 32'(busy), 32'd0);
    applyStimulus(16'h1041);
    measureMute(-1, 400, firstMute, muteLen, fieldMuted);
    checkOutput("ed_mute_len", 32'(muteLen), 32'd81);
    checkOutput("ed_major_mode", 32'(major_mode), 32'd1);
    checkOutput("ed_threshold", 32'(lf_ed_threshold), 32'd127);
    checkOutput("ed_conf_word", 32'(conf_word), 32'h041);

    // Divisor change with a frame that never ends: drain times out
    ssp_frame_in = 1'b1;
    applyStimulus(16'h2059);
    measureMute(-1, 600, firstMute, muteLen, fieldMuted);
    checkOutput("div_to_first_mute", 32'(firstMute), 32'd257);
    checkOutput("div_to_mute_len", 32'(muteLen), 32'd81);
    checkOutput("div_to_value", 32'(divisor), 32'h59);
    checkOutput("div_to_busy", 32'(busy), 32'd0);

    // Frame ends in cycle 10, so blanking starts in cycle 11
    ssp_frame_in = 1'b1;
    applyStimulus(16'h2033);
    measureMute(10, 600, firstMute, muteLen, fieldMuted);
    checkOutput("div_drop_first_mute", 32'(firstMute), 32'd11);
    checkOutput("div_drop_mute_len", 32'(muteLen), 32'd81);
    checkOutput("div_drop_value", 32'(divisor), 32'h33);
    ssp_frame_in = 1'b0;

    // Same divisor again is a no-op
    applyStimulus(16'h2033);
    checkOutput("div_same_busy", 32'(busy), 32'd0);
    checkOutput("div_same_value", 32'(divisor), 32'h33);

    // Pending slot and overflow while a divisor sequence runs
    applyStimulus(16'h2044);
    applyStimulus(16'h3011);
    applyStimulus(16'h3022);
    checkOutput("pend_overflow_set", 32'(cmd_overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("pend_overflow_clr", 32'(cmd_overflow), 32'd0);
    cmd_word  = 16'h3033;
    cmd_valid = 1'b1;
    ovf_clr   = 1'b1;
    tick();
    cmd_valid = 1'b0;
    ovf_clr   = 1'b0;
    checkOutput("pend_set_beats_clr", 32'(cmd_overflow), 32'd1);
    checkOutput("pend_thr_held", 32'(lf_ed_threshold), 32'd127);
    waitIdle(200);
    checkOutput("pend_idle", 32'(busy), 32'd0);
    checkOutput("pend_thr_before", 32'(lf_ed_threshold), 32'd127);
    tick();
    checkOutput("pend_thr_applied", 32'(lf_ed_threshold), 32'h11);
    checkOutput("pend_divisor", 32'(divisor), 32'h44);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick(); tick();
    checkOutput("pend_overflow_final", 32'(cmd_overflow), 32'd0);
    checkOutput("pend_thr_final", 32'(lf_ed_threshold), 32'h11);

    // Reset in the middle of blanking with a held command and overflow
    applyStimulus(16'h1081);
    applyStimulus(16'h3099);
    applyStimulus(16'h30AA);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("rstmid_mute_before", 32'(mute), 32'd1);
    checkOutput("rstmid_ovf_before", 32'(cmd_overflow), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("rstmid_mute", 32'(mute), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_conf", 32'(conf_word), 32'h1C0);
    checkOutput("rstmid_divisor", 32'(divisor), 32'd95);
    checkOutput("rstmid_thr", 32'(lf_ed_threshold), 32'd127);
    checkOutput("rstmid_overflow", 32'(cmd_overflow), 32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    checkOutput("rstmid_slot_empty", 32'(lf_ed_threshold), 32'd127);
    checkOutput("rstmid_still_idle", 32'(busy), 32'd0);

    // Same-mode config write takes the fast path
    applyStimulus(16'h11C3);
    checkOutput("conf_fast_word", 32'(conf_word), 32'h1C3);
    checkOutput("conf_fast_busy", 32'(busy), 32'd0);
    checkOutput("conf_fast_field", 32'(lf_field), 32'd1);
    checkOutput("conf_fast_toggle", 32'(lf_ed_toggle_mode), 32'd1);

    // Unknown opcode leaves everything alone
    applyStimulus(16'hF123);
    tick();
    checkOutput("unk_conf", 32'(conf_word), 32'h1C3);
    checkOutput("unk_divisor", 32'(divisor), 32'd95);
    checkOutput("unk_thr", 32'(lf_ed_threshold), 32'd127);
    checkOutput("unk_busy", 32'(busy), 32'd0);
    checkOutput("unk_mute", 32'(mute), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/lf_mode_sequencer.md
Name: lf_mode_sequencer

Overview:
- Synchronous command decoder and mode-transition controller for the LF FPGA image, clocked on pck0.
- Consumes 16-bit ARM command words (4-bit opcode + 12-bit data) that are already synchronised into the pck0 domain.
- Drives conf_word, major_mode, divisor and lf_ed_threshold to the LF mode muxes and the clock divider.
- Sequences major-mode and divisor changes glitch-free: drain the current SSP frame, mute the mux outputs with the field off, commit, then settle.

Parameters:
- GUARD_CYCLES, 64: pck0 cycles muted with field off before commit.
- SETTLE_CYCLES, 16: pck0 cycles muted after commit.
- DRAIN_TIMEOUT, 256: maximum pck0 cycles spent waiting for ssp_frame_in to drop.
- DIV_DEFAULT, 95: divisor reset value (125 kHz).
- THR_DEFAULT, 127: edge-detect threshold reset value, also applied on entry to edge-detect mode.

Ports:
- pck0  in  1  sole clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  single-cycle strobe; cmd_word valid.
- cmd_word  in  16  [15:12] opcode, [11:0] data.
- ssp_frame_in  in  1  muxed ssp_frame; high = frame in progress.
- ovf_clr  in  1  clears cmd_overflow.
- conf_word  out  12  committed configuration word.
- major_mode  out  3  conf_word[8:6].
- lf_field  out  1  conf_word[0], forced 0 while muted.
- lf_ed_toggle_mode  out  1  conf_word[1].
- divisor  out  8  clock-divider value.
- lf_ed_threshold  out  8  edge-detect threshold.
- mute  out  1  forces all mux outputs to 0 when high.
- busy  out  1  high in any state other than IDLE.
- cmd_overflow  out  1  sticky; set when a command is dropped.

Behaviour:
- Reset values:
  - conf_word = 12'h1C0 (major_mode 7 = OFF, field 0).
  - divisor = DIV_DEFAULT, lf_ed_threshold = THR_DEFAULT.
  - mute = 0, busy = 0, cmd_overflow = 0, state IDLE, pending slot empty.
  - Reset mid-sequence aborts immediately to these values.
- Opcodes (FPGA_CMD_* defines): SET_CONFREG = 1, SET_DIVISOR = 2, SET_EDGE_DETECT_THRESHOLD = 3. Any other opcode is ignored with no state change.
- Command source in IDLE: the pending slot if it is full, otherwise a live cmd_valid.
- Fast path, applied on the next cycle (latency 1), no mute, state stays IDLE:
  - SET_EDGE_DETECT_THRESHOLD: lf_ed_threshold <= data[7:0].
  - SET_CONFREG with data[8:6] == current major_mode: conf_word <= data.
- Slow path: SET_CONFREG with a new major mode, or SET_DIVISOR with a value different from the current divisor (equal value = no-op). Latch the target value, then sequence:
  - DRAIN: mute 0. Leave when ssp_frame_in is sampled low, or after DRAIN_TIMEOUT cycles.
  - BLANK: mute 1, lf_field 0, for GUARD_CYCLES cycles.
  - COMMIT, one cycle: mute 1; update conf_word or divisor. If the new major_mode is LF_EDGE_DETECT (1), lf_ed_threshold <= THR_DEFAULT.
  - SETTLE: mute 1 for SETTLE_CYCLES cycles, then IDLE with mute 0.
- Timing: first mute cycle follows DRAIN exit by 1 cycle; mute stays high for exactly GUARD_CYCLES + 1 + SETTLE_CYCLES cycles.
- Pending slot (1 deep) while busy:
  - cmd_valid is stored if the slot is empty; otherwise the command is dropped and cmd_overflow is set.
  - On return to IDLE the pending command is processed on the following cycle.
  - A cmd_valid arriving in that same cycle fills the freed slot.
- cmd_overflow: set takes priority over ovf_clr in the same cycle.
- Counter: a single down-counter of width $clog2(max(GUARD, SETTLE, DRAIN_TIMEOUT)) + 1, reloaded on every state entry. No wrap-around: the state advances when the count reaches 0.

Decomposition:
- Package lf_ctrl_pkg holds:
  - opcode constants;
  - major-mode codes (LF_READER 0, LF_EDGE_DETECT 1, LF_PASSTHRU 2, LF_ADC 3, OFF 7);
  - the state enum {IDLE, DRAIN, BLANK, COMMIT, SETTLE};
  - the default values.
- One sub-module, lf_cmd_slot: the 1-deep pending register with valid flag, overflow detection and the clear input.
- The FSM and down-counter stay in lf_mode_sequencer.

Test Plan:
- Reset released -> major_mode = 7, divisor = 95, lf_ed_threshold = 127, mute = 0, busy = 0.
- cmd_word 0x1001 with ssp_frame_in = 0 -> busy = 1; mute high for 81 cycles; major_mode = 0 and lf_field = 1 after SETTLE; busy = 0 afterwards.
- From mode 0, cmd 0x3050 -> lf_ed_threshold = 0x50 one cycle later, mute never asserted. Then cmd 0x1041 -> after the sequence major_mode = 1 and lf_ed_threshold = 127.
- Hold ssp_frame_in = 1 and send 0x2059 -> mute rises 257 cycles after the strobe (DRAIN timeout); divisor = 0x59 at COMMIT. Repeat with ssp_frame_in falling at cycle 10 -> mute rises at cycle 11.
- During a busy sequence send 0x3011, 0x3022, 0x3033 -> 0x3011 is held pending and applied after IDLE (threshold = 0x11); the other two are dropped; cmd_overflow = 1 until an ovf_clr pulse.
- Assert rst during BLANK -> next cycle all outputs hold their reset values and the pending slot is empty. Unknown opcode 0xF123 -> no output change.
